// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack channel plus the decoder-facing
// valid/ready word stream and the redirect input.
interface instruction_fetch_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] ins;
   logic [31:0] ins_pc;
   logic        ins_valid;
   logic        ins_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   modport master (
      output mem_req, mem_addr, ins, ins_pc, ins_valid,
      input  mem_ack, mem_rdata, ins_ready, redirect, redirect_pc
   );

   modport slave (
      input  mem_req, mem_addr, ins, ins_pc, ins_valid,
      output mem_ack, mem_rdata, ins_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding word reads into a small prefetch FIFO,
// with redirect flushing both the buffer and any in-flight fetch.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input logic               clk,
   input logic               rst_n,
   instruction_fetch_if.master bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic          mem_req;
   logic [31:0]   mem_addr;
   logic [31:0]   word_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          flush;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

   // A redirect in the ack cycle drops the returning word as stale.
   assign push  = (state == WAIT) && bus.mem_ack && !bus.redirect;
   assign pop   = (count != '0) && bus.ins_ready;
   assign flush = bus.redirect;

   assign bus.mem_req   = mem_req;
   assign bus.mem_addr  = mem_addr;
   assign bus.ins       = word_mem[rd_ptr];
   assign bus.ins_pc    = pc_mem[rd_ptr];
   assign bus.ins_valid = (count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         fetch_pc <= RESET_PC;
         mem_req  <= 1'b0;
         mem_addr <= RESET_PC;
      end else begin
         unique case (state)
            FETCH: begin
               if (bus.redirect) begin
                  fetch_pc <= align_pc(bus.redirect_pc);
               end else if (count < CW'(DEPTH)) begin
                  mem_req  <= 1'b1;
                  mem_addr <= fetch_pc;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (bus.mem_ack) begin
                  mem_req  <= 1'b0;
                  state    <= FETCH;
                  fetch_pc <= bus.redirect ? align_pc(bus.redirect_pc) : fetch_pc + 32'd4;
               end else if (bus.redirect) begin
                  // Address must stay put until the ack, so remember to drop it.
                  state    <= DISCARD;
                  fetch_pc <= align_pc(bus.redirect_pc);
               end
            end
            DISCARD: begin
               if (bus.redirect) fetch_pc <= align_pc(bus.redirect_pc);
               if (bus.mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is reset so that ins/ins_pc read as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            word_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else if (push) begin
         word_mem[wr_ptr] <= bus.mem_rdata;
         pc_mem[wr_ptr]   <= mem_addr;
      end
   end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Owns the fetch PC and issues one-outstanding word reads to instruction memory over a req/ack handshake.
- Buffers fetched words in a small prefetch FIFO and presents them to the decoder with valid/ready.
- Accepts a redirect (branch or PC-write from the `c_pcchange` path) that flushes the buffer and any in-flight fetch.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2, prefetch FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  fetch request, held until acked.
- mem_addr  out  32  word-aligned fetch address, stable while mem_req=1.
- mem_ack  in  1  transfer completes in any cycle with mem_req=1 and mem_ack=1.
- mem_rdata  in  32  instruction word, valid in the ack cycle.
- ins  out  32  FIFO head word, to decoder `ins`.
- ins_pc  out  32  address the head word was fetched from.
- ins_valid  out  1  head valid (count != 0).
- ins_ready  in  1  decoder consumes head when ins_valid&ins_ready.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced to 0).

Behaviour:
- Reset (async assert): mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, FIFO count=0, ins_valid=0, state=FETCH. ins and ins_pc reset to 0.
- mem_req, mem_addr, ins, ins_pc and ins_valid are all driven from registers or FIFO storage; none has a combinational path from any input.
- FSM states:
  - FETCH: no request outstanding.
  - WAIT: request outstanding, data kept.
  - DISCARD: request outstanding, data to be dropped.
- FETCH:
  - If count < DEPTH and no redirect: assert mem_req with mem_addr=fetch_pc on the next edge, go to WAIT.
  - Otherwise mem_req stays low.
- WAIT, mem_ack=1 and no redirect:
  - Push {mem_rdata, mem_addr}.
  - fetch_pc += 4, wrapping modulo 2^32.
  - Drop mem_req, go to FETCH. Back-to-back requests therefore have one idle cycle between them.
- WAIT, no ack: hold mem_req and mem_addr unchanged.
- Redirect while a request is outstanding (state WAIT, no ack that cycle):
  - Go to DISCARD, keep mem_req/mem_addr unchanged (protocol forbids changing the address).
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Flush the FIFO.
- DISCARD, mem_ack=1: drop rdata, no push, no fetch_pc increment, go to FETCH. Further redirects while in DISCARD only update fetch_pc.
- Redirect in the same cycle as mem_ack: the acked word is dropped, fetch_pc <= redirect_pc aligned, go to FETCH.
- Redirect in FETCH: flush, load fetch_pc; the first request to the new PC is issued the cycle after the redirect.
- Redirect with a pop in the same cycle: the pop counts as consumed (the decoder sees the head); all remaining entries are flushed; ins_valid=0 the next cycle.
- FIFO rules:
  - Push and pop in the same cycle leave count unchanged.
  - Pop with count=0 is ignored.
  - A push can never overflow, because requests are issued only when count < DEPTH and only one request is outstanding.
  - Read/write pointers wrap modulo DEPTH.
  - Flush zeroes count and both pointers.
- Latency: reset release -> mem_req at the first edge after release. Ack in cycle N -> ins_valid=1 in cycle N+1 with ins=rdata and ins_pc=addr.
- Reset mid-transaction: mem_req drops immediately (asynchronously); memory must abandon the transfer; fetch restarts at RESET_PC.

Test Plan:
- Reset release with memory acking one cycle after each request, ins_ready=1: addresses 0x0, 0x4, 0x8 are requested; ins/ins_pc show the matching words in order; ins_valid is high one cycle after each ack.
- ins_ready=0 with DEPTH=2: exactly two words are fetched (0x0, 0x4), mem_req then stays low, count=2. Raise ins_ready for one cycle -> the 0x0 word is popped and a request to 0x8 issues the next cycle.
- Redirect to 0x103 while a request to 0x8 is outstanding with ack delayed 3 cycles: mem_addr stays 0x8 until ack, the 0x8 data is never pushed, the next request is to 0x100, and no stale ins_valid appears in between.
- Redirect to 0x200 in the same cycle as the ack for 0x4: the 0x4 word is dropped, the FIFO is empty the next cycle, and the next request is to 0x200.
- FIFO holding 1 entry, ack and ins_valid&ins_ready in the same cycle: count stays 1, and the head becomes the newly fetched word with its correct ins_pc.
- Assert rst_n=0 mid-WAIT with a FIFO entry present: mem_req and ins_valid fall without waiting for clk; after release the first request is to RESET_PC.
